// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared core types plus hazard controller state, latch indices and decode helper
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    localparam int LATCH_N = 4;

    // Latch index constants into en/flush vectors
    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } hazard_state_t;

    // One cycle's sequencing decision plus the events the perf counters watch
    typedef struct packed {
        logic                pc_en;
        logic [LATCH_N-1:0]  en;
        logic [LATCH_N-1:0]  flush;
        hazard_state_t       nxt;
        logic                ev_stall;
        logic                ev_flush;
        logic                ev_memwait;
    } seq_dec_t;

    // RUN-state priority: mem_pend > redirect > load-use > fetch miss > normal.
    // Also used for the MEM_WAIT release cycle with mem_pend forced low.
    function automatic seq_dec_t run_eval(input logic mem_pend,
                                          input logic redirect,
                                          input logic lu,
                                          input logic ihit);
        seq_dec_t d;
        d.pc_en      = 1'b1;
        d.en         = 4'b1111;
        d.flush      = 4'b0000;
        d.nxt        = RUN;
        d.ev_stall   = 1'b0;
        d.ev_flush   = 1'b0;
        d.ev_memwait = 1'b0;
        if (mem_pend) begin
            d.pc_en      = 1'b0;
            d.en         = 4'b0000;
            d.nxt        = MEM_WAIT;
            d.ev_memwait = 1'b1;
        end else if (redirect) begin
            // PC loads the target; squash everything younger than MEM
            d.flush    = 4'b0111;
            d.nxt      = ihit ? RUN : REDIRECT;
            d.ev_flush = 1'b1;
        end else if (lu) begin
            d.pc_en    = 1'b0;
            d.en       = 4'b1110;
            d.flush    = 4'b0010;
            d.ev_stall = 1'b1;
        end else if (!ihit) begin
            d.pc_en    = 1'b0;
            d.flush    = 4'b0001;
            d.ev_stall = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// rtl/hazard_perf_counters.sv - saturating stall/flush/memwait event counters
// Ports: clk, rst (sync active-high), *_inc event strobes, *_cnt counter values.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    input  logic             memwait_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if (stall_inc && !(&stall_cnt))
                stall_cnt <= stall_cnt + ONE;
            if (flush_inc && !(&flush_cnt))
                flush_cnt <= flush_cnt + ONE;
            if (memwait_inc && !(&memwait_cnt))
                memwait_cnt <= memwait_cnt + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing controller (load-use, memory freeze, redirect squash, fetch miss)
// Ports: CLK, RST (sync active-high); instr_dec/instr_exe, dREN_exe, dREN_mem, dWEN_mem,
//        dhit, ihit, redirect_mem in; pc_en, en[3:0], flush[3:0] (bit0=IF/ID..bit3=MEM/WB),
//        state_o, stall_cnt/flush_cnt/memwait_cnt out.
// Macro HAZARD_PERF_EN: when defined, counters are live; otherwise they read 0.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int NSTAGE_LATCH = 4,
    parameter int CNT_W        = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [31:0]             instr_dec,
    input  logic [31:0]             instr_exe,
    input  logic                    dREN_exe,
    input  logic                    dREN_mem,
    input  logic                    dWEN_mem,
    input  logic                    dhit,
    input  logic                    ihit,
    input  logic                    redirect_mem,
    output logic                    pc_en,
    output logic [NSTAGE_LATCH-1:0] en,
    output logic [NSTAGE_LATCH-1:0] flush,
    output logic [1:0]              state_o,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt,
    output logic [CNT_W-1:0]        memwait_cnt
);

    hazard_state_t state, state_nxt;
    regbits_t      rs1_dec, rs2_dec, rd_exe;
    logic          mem_pend, lu;
    seq_dec_t      run_d, rel_d;
    logic          ev_stall, ev_flush, ev_memwait;

    assign rs1_dec  = instr_dec[19:15];
    assign rs2_dec  = instr_dec[24:20];
    assign rd_exe   = instr_exe[11:7];
    assign mem_pend = (dREN_mem | dWEN_mem) & ~dhit;
    // rs2 compared unconditionally; an occasional false stall on I-type is harmless
    assign lu       = dREN_exe & (rd_exe != 5'd0) & ((rd_exe == rs1_dec) | (rd_exe == rs2_dec));

    assign run_d = run_eval(mem_pend, redirect_mem, lu, ihit);
    assign rel_d = run_eval(1'b0,     redirect_mem, lu, ihit);

    assign state_o = state;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = RUN;
        case (state)
            RUN:      state_nxt = run_d.nxt;
            MEM_WAIT: state_nxt = dhit ? rel_d.nxt : MEM_WAIT;
            REDIRECT: state_nxt = ihit ? RUN : REDIRECT;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en      = 1'b1;
        en         = 4'b1111;
        flush      = 4'b0000;
        ev_stall   = 1'b0;
        ev_flush   = 1'b0;
        ev_memwait = 1'b0;
        if (RST) begin
            pc_en = 1'b0;
            en    = 4'b0000;
            flush = 4'b1111;
        end else begin
            case (state)
                RUN: begin
                    pc_en      = run_d.pc_en;
                    en         = run_d.en;
                    flush      = run_d.flush;
                    ev_stall   = run_d.ev_stall;
                    ev_flush   = run_d.ev_flush;
                    ev_memwait = run_d.ev_memwait;
                end
                MEM_WAIT: begin
                    if (dhit) begin
                        // Release cycle: honour whatever was queued behind the freeze
                        pc_en    = rel_d.pc_en;
                        en       = rel_d.en;
                        flush    = rel_d.flush;
                        ev_stall = rel_d.ev_stall;
                        ev_flush = rel_d.ev_flush;
                    end else begin
                        pc_en      = 1'b0;
                        en         = 4'b0000;
                        ev_memwait = 1'b1;
                    end
                end
                REDIRECT: begin
                    if (!ihit) begin
                        pc_en        = 1'b0;
                        flush[IFID]  = 1'b1;
                        ev_stall     = 1'b1;
                    end
                end
                default: begin
                    pc_en = 1'b0;
                    en    = 4'b0000;
                    flush = 4'b1111;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk         (CLK),
        .rst         (RST),
        .stall_inc   (ev_stall),
        .flush_inc   (ev_flush),
        .memwait_inc (ev_memwait),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .memwait_cnt (memwait_cnt)
    );
`else
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign memwait_cnt = '0;
    logic unused_perf;
    assign unused_perf = &{1'b0, ev_stall, ev_flush, ev_memwait};
`endif

    logic unused_instr;
    assign unused_instr = &{1'b0, instr_dec[31:25], instr_dec[14:0],
                            instr_exe[31:12], instr_exe[6:0]};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] instr_dec, instr_exe;
    logic        dREN_exe, dREN_mem, dWEN_mem, dhit, ihit, redirect_mem;
    logic        pc_en;
    logic [3:0]  en, flush;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // lw x5 (rd=5); add x6,x5,x1; add x6,x1,x5; add x6,x0,x1
    localparam logic [31:0] LW_X5     = 32'h0000_0280;
    localparam logic [31:0] ADD_RS1X5 = 32'h0012_8333;
    localparam logic [31:0] ADD_RS2X5 = 32'h0050_8333;
    localparam logic [31:0] ADD_X0    = 32'h0010_0333;

    hazard_ctrl #(.NSTAGE_LATCH(4), .CNT_W(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .instr_dec    (instr_dec),
        .instr_exe    (instr_exe),
        .dREN_exe     (dREN_exe),
        .dREN_mem     (dREN_mem),
        .dWEN_mem     (dWEN_mem),
        .dhit         (dhit),
        .ihit         (ihit),
        .redirect_mem (redirect_mem),
        .pc_en        (pc_en),
        .en           (en),
        .flush        (flush),
        .state_o      (state_o),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .memwait_cnt  (memwait_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input logic pe, input logic [3:0] e,
                           input logic [3:0] f, input logic [1:0] s);
        chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, pe});
        chk({tag, ".en"},    {28'd0, en},    {28'd0, e});
        chk({tag, ".flush"}, {28'd0, flush}, {28'd0, f});
        chk({tag, ".state"}, {30'd0, state_o}, {30'd0, s});
        chk({tag, ".no_redirect_in_redirect"},
            {31'd0, (state_o == 2'd2) && redirect_mem}, 32'd0);
    endtask

    task automatic chk_cnt(input string tag, input int st, input int fl, input int mw);
        chk({tag, ".stall_cnt"},   stall_cnt,   PERF ? st : 0);
        chk({tag, ".flush_cnt"},   flush_cnt,   PERF ? fl : 0);
        chk({tag, ".memwait_cnt"}, memwait_cnt, PERF ? mw : 0);
    endtask

    task automatic idle;
        RST = 1'b0; instr_dec = 32'h0; instr_exe = 32'h0;
        dREN_exe = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
        dhit = 1'b0; ihit = 1'b1; redirect_mem = 1'b0;
    endtask

    task automatic next_step;
        @(negedge CLK);
        idle();
    endtask

    initial begin
        idle();
        RST = 1'b1;

        // Reset outputs
        next_step(); RST = 1'b1; #1;
        chk_seq("reset", 1'b0, 4'b0000, 4'b1111, 2'd0);
        chk_cnt("reset", 0, 0, 0);

        next_step(); #1;
        chk_seq("normal", 1'b1, 4'b1111, 4'b0000, 2'd0);

        // Load-use, rs1 and rs2 match
        next_step(); instr_exe = LW_X5; dREN_exe = 1'b1; instr_dec = ADD_RS1X5; #1;
        chk_seq("lu_rs1", 1'b0, 4'b1110, 4'b0010, 2'd0);
        next_step(); instr_exe = LW_X5; dREN_exe = 1'b1; instr_dec = ADD_RS2X5; #1;
        chk_seq("lu_rs2", 1'b0, 4'b1110, 4'b0010, 2'd0);

        // rd=x0 never stalls
        next_step(); instr_exe = 32'h0; dREN_exe = 1'b1; instr_dec = ADD_X0; #1;
        chk_seq("lu_x0", 1'b1, 4'b1111, 4'b0000, 2'd0);

        // Load-use outranks fetch miss
        next_step(); instr_exe = LW_X5; dREN_exe = 1'b1; instr_dec = ADD_RS1X5; ihit = 1'b0; #1;
        chk_seq("lu_over_imiss", 1'b0, 4'b1110, 4'b0010, 2'd0);

        next_step(); ihit = 1'b0; #1;
        chk_seq("imiss", 1'b0, 4'b1111, 4'b0001, 2'd0);

        // Memory wait: three frozen cycles then release
        next_step(); dREN_mem = 1'b1; #1;
        chk_seq("mw0", 1'b0, 4'b0000, 4'b0000, 2'd0);
        next_step(); dREN_mem = 1'b1; #1;
        chk_seq("mw1", 1'b0, 4'b0000, 4'b0000, 2'd1);
        next_step(); dREN_mem = 1'b1; #1;
        chk_seq("mw2", 1'b0, 4'b0000, 4'b0000, 2'd1);
        next_step(); dREN_mem = 1'b1; dhit = 1'b1; #1;
        chk_seq("mw_release", 1'b1, 4'b1111, 4'b0000, 2'd1);
        chk_cnt("mw_release", 4, 0, 3);
        next_step(); #1;
        chk_seq("mw_after", 1'b1, 4'b1111, 4'b0000, 2'd0);

        // Redirect with two-cycle fetch miss
        next_step(); redirect_mem = 1'b1; ihit = 1'b0; #1;
        chk_seq("rd0", 1'b1, 4'b1111, 4'b0111, 2'd0);
        next_step(); ihit = 1'b0; #1;
        chk_seq("rd1", 1'b0, 4'b1111, 4'b0001, 2'd2);
        chk_cnt("rd1", 4, 1, 3);
        next_step(); ihit = 1'b0; #1;
        chk_seq("rd2", 1'b0, 4'b1111, 4'b0001, 2'd2);
        next_step(); #1;
        chk_seq("rd_ihit", 1'b1, 4'b1111, 4'b0000, 2'd2);
        chk_cnt("rd_ihit", 6, 1, 3);
        next_step(); #1;
        chk_seq("rd_after", 1'b1, 4'b1111, 4'b0000, 2'd0);

        // Store pending with redirect: freeze first, redirect on release
        next_step(); dWEN_mem = 1'b1; redirect_mem = 1'b1; #1;
        chk_seq("sim0", 1'b0, 4'b0000, 4'b0000, 2'd0);
        next_step(); dWEN_mem = 1'b1; redirect_mem = 1'b1; #1;
        chk_seq("sim1", 1'b0, 4'b0000, 4'b0000, 2'd1);
        next_step(); dWEN_mem = 1'b1; redirect_mem = 1'b1; dhit = 1'b1; #1;
        chk_seq("sim_release", 1'b1, 4'b1111, 4'b0111, 2'd1);
        next_step(); #1;
        chk_seq("sim_after", 1'b1, 4'b1111, 4'b0000, 2'd0);
        chk_cnt("sim_after", 6, 2, 5);

        // Reset mid-MEM_WAIT
        next_step(); dREN_mem = 1'b1; #1;
        chk_seq("rst_mw0", 1'b0, 4'b0000, 4'b0000, 2'd0);
        next_step(); dREN_mem = 1'b1; RST = 1'b1; #1;
        chk_seq("rst_mw_rst", 1'b0, 4'b0000, 4'b1111, 2'd1);
        next_step(); #1;
        chk_seq("rst_mw_after", 1'b1, 4'b1111, 4'b0000, 2'd0);
        chk_cnt("rst_mw_after", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
